// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, a bus responder interface and a level IRQ.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-low reset
//   busSel    - address-decoder select for this peripheral
//   busWe     - write strobe (write happens on an edge with busSel & busWe)
//   busAddr   - byte address, only [3:2] decoded
//   busWData  - write data
//   busRData  - combinational read data, 0 when not selected
//   tx        - serial line, idles high
//   txIrq     - irqEn & fifo empty & transmitter idle
module bus_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busSel,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        tx,
    output logic        txIrq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DIV_W = 16;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Transmitter state
    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic               tx_q, tx_d;

    // Programmable registers
    logic [DIV_W-1:0]   div_q, div_d;
    logic               enable_q, enable_d;
    logic               irq_en_q, irq_en_d;
    logic               overflow_q, overflow_d;

    // FIFO bookkeeping
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               bus_wr;
    logic [1:0]         reg_sel;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               busy;
    logic               bit_end;
    logic [31:0]        rdata;

    // Address bits outside [3:2] and the upper write-data half carry no meaning here
    logic               unused_bits;
    assign unused_bits = ^{busAddr[31:4], busAddr[1:0], busWData[31:16]};

    // Decode and FIFO status
    assign bus_wr     = busSel & busWe;
    assign reg_sel    = busAddr[3:2];
    assign push_req   = bus_wr && (reg_sel == REG_DATA);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Fullness is judged before the edge, so a same-edge pop never makes room for the push
    assign push       = push_req & ~fifo_full;
    assign pop        = (state_q == ST_IDLE) & enable_q & ~fifo_empty;
    assign busy       = (state_q != ST_IDLE);
    // >= keeps a mid-bit divisor reduction from wrapping the counter
    assign bit_end    = (baud_cnt_q >= div_q);

    // Serialiser next-state and line value
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                if (pop) begin
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // Next bit is the one about to land in shift[0]
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + DIV_W'(1);
                end
            end
            default: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Register file and FIFO pointer next-state
    always_comb begin
        div_d      = div_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (bus_wr) begin
            case (reg_sel)
                REG_DATA: begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end
                end
                REG_STATUS: overflow_d = 1'b0;
                REG_BAUD:   div_d      = busWData[DIV_W-1:0];
                REG_CTRL: begin
                    enable_d = busWData[0];
                    irq_en_d = busWData[1];
                end
                default: ;
            endcase
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            div_q      <= DIV_W'(DEFAULT_DIV);
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
            div_q      <= div_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_mem[wr_ptr_q] <= busWData[7:0];
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata = '0;
        if (busSel) begin
            case (reg_sel)
                REG_DATA:   rdata = '0;
                REG_STATUS: rdata = {24'h0, 4'(count_q), overflow_q, busy, fifo_empty, fifo_full};
                REG_BAUD:   rdata = {16'h0, div_q};
                REG_CTRL:   rdata = {30'h0, irq_en_q, enable_q};
                default:    rdata = '0;
            endcase
        end
    end

    assign busRData = rdata;
    assign tx       = tx_q;
    assign txIrq    = irq_en_q & fifo_empty & ~busy;

endmodule
